// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that performs a W-bit addition one nibble per clock through an
// external combinational 4-bit adder, reporting sum, carry and signed overflow.
module nibble_serial_adder_ctrl #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 c_in,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_s,
   input  logic                 add_cout,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 c_out,
   output logic                 overflow,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned W = 4 * NIBBLES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   s_sh;
   logic [W-1:0]   s_next;
   logic           carry_reg;
   logic           sign_a;
   logic           sign_b;
   logic [3:0]     cnt;
   logic           last_nibble;

   // Incoming nibble enters at the MSB; written width-agnostically so NIBBLES=1 works.
   always_comb begin
      s_next      = (s_sh >> 4) | (W'(add_s) << (W - 4));
      last_nibble = (cnt == 4'(NIBBLES - 1));
   end

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_sh[3:0];
         add_b   = b_sh[3:0];
         add_cin = carry_reg;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         s_sh      <= '0;
         carry_reg <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         cnt       <= '0;
         sum       <= '0;
         c_out     <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh      <= op_a;
                  b_sh      <= op_b;
                  carry_reg <= c_in;
                  sign_a    <= op_a[W-1];
                  sign_b    <= op_b[W-1];
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               s_sh      <= s_next;
               carry_reg <= add_cout;
               a_sh      <= a_sh >> 4;
               b_sh      <= b_sh >> 4;
               cnt       <= cnt + 4'd1;
               if (last_nibble) begin
                  sum      <= s_next;
                  c_out    <= add_cout;
                  overflow <= (sign_a == sign_b) && (add_s[3] != sign_a);
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a wide addition one nibble per clock by driving an external 4-bit ripple carry adder.
- Upstream side: accepts a wide operand pair on a start pulse.
- Each cycle: presents one nibble pair plus the registered carry to the adder, then captures the adder's sum nibble and carry-out.
- Result: reports the wide sum, carry-out and signed overflow with a one-cycle done strobe.
- Placement: sits directly around the 4-bit adder, both feeding it and consuming its outputs, so a single 4-bit adder serves 16-bit (default) datapaths.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
clock     input   1   rising-edge clock; the block's only clock
resetn    input   1   asynchronous active-low reset
start     input   1   request; sampled only in IDLE
op_a      input   W   operand A, captured on accepted start
op_b      input   W   operand B, captured on accepted start
c_in      input   1   initial carry, captured on accepted start
add_a     output  4   to adder a
add_b     output  4   to adder b
add_cin   output  1   to adder c_in
add_s     input   4   from adder s
add_cout  input   1   from adder c_out
sum       output  W   registered result
c_out     output  1   registered final carry
overflow  output  1   registered two's-complement overflow
busy      output  1   high in RUN and DONE
done      output  1   one-cycle strobe, result valid

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - sum=0, c_out=0, overflow=0, busy=0, done=0.
  - Internal shift registers, nibble counter and carry register cleared.
  - Reset mid-operation aborts the add immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - add_a, add_b and add_cin driven to 0.
  - On an edge with start=1: latch op_a and op_b into A/B shift registers, carry_reg<=c_in, and save the sign bits of op_a and op_b. Counter<=0. Go to RUN.
  - sum, c_out and overflow hold their previous values until RUN writes them.
- RUN:
  - add_a=A_sh[3:0], add_b=B_sh[3:0], add_cin=carry_reg; all three are purely combinational from registers.
  - Each edge:
    - S_sh <= {add_s, S_sh[W-1:4]}; the nibble enters at the MSB and shifts right.
    - carry_reg <= add_cout.
    - A_sh and B_sh shift right by 4.
    - Counter increments.
  - On the edge where counter==NIBBLES-1:
    - sum <= final S_sh including this nibble.
    - c_out <= add_cout.
    - overflow <= (signA==signB) && (add_s[3]!=signA).
    - Go to DONE.
  - The adder is treated as combinational and must settle within one clock period.
- DONE:
  - done=1 for exactly one cycle.
  - add_* outputs driven to 0.
  - Unconditionally returns to IDLE.
- Latency:
  - start accepted at edge 0.
  - Result registered at edge NIBBLES.
  - done high during the cycle following edge NIBBLES.
  - A new start is accepted at the earliest on edge NIBBLES+2.
- busy=1 in RUN and DONE. start while busy is ignored; op_a, op_b and c_in changes while busy have no effect.
- Wrap-around: the sum is W bits modulo 2^W; the carry past bit W-1 appears only on c_out.
- op_a, op_b and c_in are don't-care when no start is accepted.

Test Plan:
- Basic add: 0x1234 + 0x4321, c_in=0 -> sum=0x5555, c_out=0, overflow=0. done high exactly in cycle 5 after the start edge, and for exactly one cycle.
- Carry ripples across all nibbles: 0xFFFF + 0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0. Bench checks that add_cin is 1 in RUN cycles 2-4.
- Signed overflow: 0x7FFF + 0x0001 -> sum=0x8000, c_out=0, overflow=1. Also 0x8000 + 0x8000 -> sum=0x0000, c_out=1, overflow=1.
- Initial carry: 0x000F + 0x0000, c_in=1 -> sum=0x0010, c_out=0. add_cin=1 in the first RUN cycle.
- start held high through an operation, with op_a changed mid-run: only one result is produced, computed from the originally captured operands. The next operation begins at edge 6.
- Reset asserted asynchronously in RUN cycle 2 -> outputs zero immediately (not at the next edge). No done pulse. A fresh start after release gives the correct 0x1234 + 0x4321 result.
